// File: rtl/des_pkg.sv
// Shared DES key-schedule constants: PC-1/PC-2 tables, shift schedule, modes, FSM states.
// Latency: none (package of constants and pure helper functions).
// Backpressure: not applicable.
package des_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  // PC-1: entry n is the key bit (DES numbering, 1 = MSB) that lands in C/D bit n+1.
  localparam int unsigned PC1 [0:55] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  // PC-2: entry n is the C/D bit that lands in round-key bit n+1.
  localparam int unsigned PC2 [0:47] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // SHIFT(r) for round r = 1..16 lives at index r-1.
  localparam int unsigned SHIFT [0:15] = '{
    1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1
  };

  // Left rotate a 28-bit half (bit 1 = MSB) by 1 or, when two is set, by 2.
  function automatic logic [1:28] rotl28(input logic [1:28] x, input logic two);
    return two ? {x[3:28], x[1:2]} : {x[2:28], x[1]};
  endfunction

  // Right rotate a 28-bit half by 1 or, when two is set, by 2.
  function automatic logic [1:28] rotr28(input logic [1:28] x, input logic two);
    return two ? {x[27:28], x[1:26]} : {x[28], x[1:27]};
  endfunction

endpackage

// File: rtl/des_pc2.sv
// DES PC-2 compression: 56-bit C/D register to 48-bit round key, pure wiring.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows input.
module des_pc2
  import des_pkg::*;
(
  input  logic [1:56] cd_i,
  output logic [1:48] rk_o
);

  for (genvar i = 0; i < 48; i++) begin : g_bit
    assign rk_o[i+1] = cd_i[PC2[i]];
  end

  // PC-2 discards these eight C/D bits by construction.
  logic unused_dropped;
  assign unused_dropped = ^{cd_i[9], cd_i[18], cd_i[22], cd_i[25],
                            cd_i[35], cd_i[38], cd_i[43], cd_i[54]};

endmodule

// File: rtl/des_key_schedule.sv
// Sequential DES round-key generator: 16 keys, K1..K16 (encrypt) or K16..K1 (decrypt).
// Latency: first key one cycle after start, then one key per handshake; done 17 cycles after start.
// Backpressure: rk_ready low holds CD, rk_index and round_key; rk_valid stays high.
module des_key_schedule
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:64] key_in,
  input  logic        mode,
  input  logic        start,
  output logic        busy,
  output logic        rk_valid,
  input  logic        rk_ready,
  output logic [3:0]  rk_index,
  output logic [1:48] round_key,
  output logic        done
);

  state_t      state_q, state_d;
  logic [1:56] cd_q, cd_d;
  logic [4:0]  idx_q, idx_d;
  logic        mode_q, mode_d;
  logic        done_q, done_d;

  // PC-1 straight from the key pins; parity bits (every 8th) never reach CD.
  logic [1:56] pc1_key;
  for (genvar i = 0; i < 56; i++) begin : g_pc1
    assign pc1_key[i+1] = key_in[PC1[i]];
  end

  logic unused_parity;
  assign unused_parity = ^{key_in[8],  key_in[16], key_in[24], key_in[32],
                           key_in[40], key_in[48], key_in[56], key_in[64]};

  // Encrypt advances to K(i+1) using SHIFT(i+1), stored at index i.
  // Decrypt steps back from K(17-i) to K(16-i), undoing SHIFT(17-i) at index 16-i;
  // for i in 1..15 that index is just -i modulo 16.
  logic [3:0] sel_enc, sel_dec;
  logic       two_enc, two_dec;
  assign sel_enc = idx_q[3:0];
  assign sel_dec = 4'd0 - idx_q[3:0];
  assign two_enc = (SHIFT[sel_enc] == 2);
  assign two_dec = (SHIFT[sel_dec] == 2);

  // Next-state: load on start in IDLE, step CD on each accepted key in RUN.
  always_comb begin
    state_d = state_q;
    cd_d    = cd_q;
    idx_d   = idx_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d  = mode;
          idx_d   = 5'd1;
          state_d = RUN;
          if (mode == MODE_DEC) begin
            cd_d = pc1_key;
          end else begin
            cd_d = {rotl28(pc1_key[1:28], 1'b0), rotl28(pc1_key[29:56], 1'b0)};
          end
        end
      end
      RUN: begin
        if (rk_ready) begin
          if (idx_q == 5'd16) begin
            state_d = IDLE;
            idx_d   = 5'd0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 5'd1;
            if (mode_q == MODE_DEC) begin
              cd_d = {rotr28(cd_q[1:28], two_dec), rotr28(cd_q[29:56], two_dec)};
            end else begin
              cd_d = {rotl28(cd_q[1:28], two_enc), rotl28(cd_q[29:56], two_enc)};
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cd_q    <= '0;
      idx_q   <= '0;
      mode_q  <= MODE_ENC;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cd_q    <= cd_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign rk_valid = (state_q == RUN);
  assign rk_index = idx_q[3:0];  // sequence number 16 shows as 4'h0
  assign done     = done_q;

  des_pc2 u_pc2 (
    .cd_i (cd_q),
    .rk_o (round_key)
  );

endmodule

// File: tb/tb_des_key_schedule.sv
// Self-checking bench for des_key_schedule against a whole-schedule DES key model.
// Latency: checks first key at T+1 and done at T+17.
// Backpressure: random rk_ready stalls with hold-stability checks.
module tb_des_key_schedule;

  logic        clk;
  logic        rst_n;
  logic [63:0] key_in;
  logic        mode;
  logic        start;
  logic        busy;
  logic        rk_valid;
  logic        rk_ready;
  logic [3:0]  rk_index;
  logic [47:0] round_key;
  logic        done;

  des_key_schedule dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_in    (key_in),
    .mode      (mode),
    .start     (start),
    .busy      (busy),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .rk_index  (rk_index),
    .round_key (round_key),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [63:0] KEY    = 64'h133457799BBCDFF1;
  localparam logic [63:0] PARITY = 64'h0101010101010101;
  localparam logic [47:0] K1_REF  = 48'h1B02EFFC7072;
  localparam logic [47:0] K2_REF  = 48'h79AED9DBC9E5;
  localparam logic [47:0] K16_REF = 48'hCB3D8B0E17F5;

  int PC1_T [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                     19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                     14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
  int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                     41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
  int SH_T  [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  int n_checks = 0;
  int n_fail   = 0;

  logic [47:0] exp_k   [1:16];
  logic [47:0] enc_ref [16];
  logic [47:0] got_key [16];
  logic [3:0]  got_idx [16];
  int   cyc, stall_bad, valid_drop, done_early;
  logic timeout, done_seen, post_valid, post_busy, done_after, after_valid;
  logic [3:0] post_idx;

  // Reference: Kn = PC-2(rotl(C0, s_n) || rotl(D0, s_n)), s_n = cumulative shift.
  task automatic compute_model(input logic [63:0] key);
    logic [27:0] c0, d0, c, d;
    logic [55:0] cd;
    int s;
    for (int i = 0; i < 28; i++) begin
      c0[27-i] = key[64-PC1_T[i]];
      d0[27-i] = key[64-PC1_T[i+28]];
    end
    s = 0;
    for (int n = 1; n <= 16; n++) begin
      s += SH_T[n-1];
      c = (c0 << s) | (c0 >> (28 - s));
      d = (d0 << s) | (d0 >> (28 - s));
      cd = {c, d};
      for (int j = 0; j < 48; j++) exp_k[n][47-j] = cd[56-PC2_T[j]];
    end
  endtask

  task automatic start_seq(input logic [63:0] key, input logic md);
    key_in = key;
    mode   = md;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  // Drives rk_ready and captures the 16 handshaken keys; ends one cycle after done.
  task automatic collect(input logic stall_en, input logic inject5, input logic [63:0] inj_key,
                         input logic chain, input logic [63:0] chain_key, input logic chain_mode);
    int hs;
    logic have_prev, injected, rdy;
    logic [47:0] prev_k;
    logic [3:0]  prev_i;
    hs = 0; cyc = 1; stall_bad = 0; valid_drop = 0; done_early = 0;
    timeout = 1'b0; have_prev = 1'b0; injected = 1'b0;
    while (hs < 16) begin
      if (cyc > 400) begin timeout = 1'b1; break; end
      if (!rk_valid || !busy) valid_drop++;
      if (done) done_early++;
      if (have_prev && (round_key !== prev_k || rk_index !== prev_i)) stall_bad++;
      if (inject5 && rk_index == 4'd5 && !injected) begin
        start = 1'b1; key_in = inj_key; mode = ~mode; injected = 1'b1;
      end else begin
        start = 1'b0;
      end
      rdy = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      rk_ready = rdy;
      if (rdy) begin
        got_key[hs] = round_key;
        got_idx[hs] = rk_index;
        hs++;
        have_prev = 1'b0;
      end else begin
        have_prev = 1'b1; prev_k = round_key; prev_i = rk_index;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    rk_ready = 1'b1;
    done_seen = done; post_valid = rk_valid; post_busy = busy; post_idx = rk_index;
    if (chain) begin
      key_in = chain_key; mode = chain_mode; start = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    done_after = done;
    after_valid = rk_valid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (rk_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", rk_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    n_checks++; if (round_key !== 48'h0) begin n_fail++; $display("FAIL reset_key got=%h exp=0", round_key); end
    n_checks++; if (rk_index !== 4'd0) begin n_fail++; $display("FAIL reset_index got=%0d exp=0", rk_index); end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (rk_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid got=%b exp=0", rk_valid); end
  endtask

  task automatic test_encrypt();
    compute_model(KEY);
    start_seq(KEY, 1'b0);
    collect(1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
    n_checks++; if (timeout) begin n_fail++; $display("FAIL enc_timeout got=1 exp=0"); end
    n_checks++; if (got_key[0] !== K1_REF) begin n_fail++; $display("FAIL enc_k1 got=%h exp=%h", got_key[0], K1_REF); end
    n_checks++; if (got_key[1] !== K2_REF) begin n_fail++; $display("FAIL enc_k2 got=%h exp=%h", got_key[1], K2_REF); end
    n_checks++; if (got_key[15] !== K16_REF) begin n_fail++; $display("FAIL enc_k16 got=%h exp=%h", got_key[15], K16_REF); end
    for (int j = 0; j < 16; j++) begin
      n_checks++; if (got_key[j] !== exp_k[j+1]) begin n_fail++; $display("FAIL enc_model[%0d] got=%h exp=%h", j, got_key[j], exp_k[j+1]); end
      n_checks++; if (got_idx[j] !== 4'(j + 1)) begin n_fail++; $display("FAIL enc_index[%0d] got=%0d exp=%0d", j, got_idx[j], 4'(j + 1)); end
      enc_ref[j] = got_key[j];
    end
    n_checks++; if (cyc != 17) begin n_fail++; $display("FAIL enc_latency got=%0d exp=17", cyc); end
    n_checks++; if (done_seen !== 1'b1) begin n_fail++; $display("FAIL enc_done got=%b exp=1", done_seen); end
    n_checks++; if (done_early != 0) begin n_fail++; $display("FAIL enc_done_early got=%0d exp=0", done_early); end
    n_checks++; if (post_valid !== 1'b0 || post_busy !== 1'b0) begin n_fail++; $display("FAIL enc_post_idle got=%b%b exp=00", post_valid, post_busy); end
    n_checks++; if (post_idx !== 4'd0) begin n_fail++; $display("FAIL enc_post_index got=%0d exp=0", post_idx); end
    n_checks++; if (done_after !== 1'b0) begin n_fail++; $display("FAIL enc_done_width got=%b exp=0", done_after); end
  endtask

  task automatic test_decrypt();
    start_seq(KEY, 1'b1);
    collect(1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
    n_checks++; if (got_key[0] !== K16_REF) begin n_fail++; $display("FAIL dec_first got=%h exp=%h", got_key[0], K16_REF); end
    n_checks++; if (got_key[15] !== K1_REF) begin n_fail++; $display("FAIL dec_last got=%h exp=%h", got_key[15], K1_REF); end
    for (int j = 0; j < 16; j++) begin
      n_checks++; if (got_key[j] !== enc_ref[15-j]) begin n_fail++; $display("FAIL dec_reverse[%0d] got=%h exp=%h", j, got_key[j], enc_ref[15-j]); end
    end
    n_checks++; if (cyc != 17 || done_seen !== 1'b1) begin n_fail++; $display("FAIL dec_done got=%0d/%b exp=17/1", cyc, done_seen); end
  endtask

  task automatic test_random_keys();
    logic [63:0] k;
    logic md;
    for (int t = 0; t < 4; t++) begin
      k  = {$urandom, $urandom};
      md = 1'($urandom_range(0, 1));
      compute_model(k);
      start_seq(k, md);
      collect(1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
      for (int j = 0; j < 16; j++) begin
        n_checks++;
        if (got_key[j] !== (md ? exp_k[16-j] : exp_k[j+1])) begin
          n_fail++; $display("FAIL rand_key t%0d[%0d] got=%h exp=%h", t, j, got_key[j], md ? exp_k[16-j] : exp_k[j+1]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    start_seq(KEY, 1'b0);
    collect(1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
    n_checks++; if (timeout) begin n_fail++; $display("FAIL bp_timeout got=1 exp=0"); end
    n_checks++; if (stall_bad != 0) begin n_fail++; $display("FAIL bp_stall_hold got=%0d exp=0", stall_bad); end
    n_checks++; if (valid_drop != 0) begin n_fail++; $display("FAIL bp_valid_drop got=%0d exp=0", valid_drop); end
    n_checks++; if (done_early != 0 || done_seen !== 1'b1) begin n_fail++; $display("FAIL bp_done got=%0d/%b exp=0/1", done_early, done_seen); end
    for (int j = 0; j < 16; j++) begin
      n_checks++; if (got_key[j] !== enc_ref[j]) begin n_fail++; $display("FAIL bp_key[%0d] got=%h exp=%h", j, got_key[j], enc_ref[j]); end
    end
  endtask

  task automatic test_start_ignored();
    start_seq(KEY, 1'b0);
    collect(1'b0, 1'b1, {$urandom, $urandom}, 1'b0, 64'h0, 1'b0);
    for (int j = 0; j < 16; j++) begin
      n_checks++; if (got_key[j] !== enc_ref[j]) begin n_fail++; $display("FAIL ign_key[%0d] got=%h exp=%h", j, got_key[j], enc_ref[j]); end
    end
    n_checks++; if (cyc != 17 || done_seen !== 1'b1) begin n_fail++; $display("FAIL ign_done got=%0d/%b exp=17/1", cyc, done_seen); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] k2;
    k2 = {$urandom, $urandom};
    start_seq(KEY, 1'b0);
    collect(1'b0, 1'b0, 64'h0, 1'b1, k2, 1'b0);
    n_checks++; if (done_seen !== 1'b1) begin n_fail++; $display("FAIL b2b_done got=%b exp=1", done_seen); end
    n_checks++; if (after_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_restart got=%b exp=1", after_valid); end
    compute_model(k2);
    collect(1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
    for (int j = 0; j < 16; j++) begin
      n_checks++; if (got_key[j] !== exp_k[j+1]) begin n_fail++; $display("FAIL b2b_key[%0d] got=%h exp=%h", j, got_key[j], exp_k[j+1]); end
    end
    n_checks++; if (cyc != 17 || done_seen !== 1'b1) begin n_fail++; $display("FAIL b2b_second_done got=%0d/%b exp=17/1", cyc, done_seen); end
  endtask

  task automatic test_reset_midrun();
    int n, dones;
    start_seq(KEY, 1'b0);
    rk_ready = 1'b1;
    n = 0;
    while (rk_index !== 4'd8 && n < 40) begin @(negedge clk); n++; end
    n_checks++; if (rk_index !== 4'd8) begin n_fail++; $display("FAIL rst_reach8 got=%0d exp=8", rk_index); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++; if (rk_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_idle got=%b%b exp=00", rk_valid, busy); end
    n_checks++; if (round_key !== 48'h0) begin n_fail++; $display("FAIL rst_mid_key got=%h exp=0", round_key); end
    n_checks++; if (rk_index !== 4'd0) begin n_fail++; $display("FAIL rst_mid_index got=%0d exp=0", rk_index); end
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      if (done) dones++;
      @(negedge clk);
    end
    n_checks++; if (dones != 0) begin n_fail++; $display("FAIL rst_mid_no_done got=%0d exp=0", dones); end
    start_seq(KEY, 1'b0);
    n_checks++; if (rk_valid !== 1'b1 || round_key !== K1_REF) begin n_fail++; $display("FAIL rst_restart_k1 got=%b/%h exp=1/%h", rk_valid, round_key, K1_REF); end
    collect(1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
  endtask

  task automatic test_parity();
    logic [47:0] a [16];
    start_seq(KEY, 1'b0);
    collect(1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
    for (int j = 0; j < 16; j++) a[j] = got_key[j];
    start_seq(KEY ^ PARITY, 1'b0);
    collect(1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
    for (int j = 0; j < 16; j++) begin
      n_checks++; if (got_key[j] !== a[j] || got_key[j] !== enc_ref[j]) begin n_fail++; $display("FAIL parity_key[%0d] got=%h exp=%h", j, got_key[j], enc_ref[j]); end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; rk_ready = 1'b0; key_in = '0; mode = 1'b0;
    @(negedge clk);
    test_reset();
    test_encrypt();
    test_decrypt();
    test_random_keys();
    test_backpressure();
    test_start_ignored();
    test_back_to_back();
    test_reset_midrun();
    test_parity();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
